alu_seq: RTL and testbench

Parametrised multi-cycle ALU for the MIPS datapath.
- Single-cycle logic and arithmetic ops.
- Iterative variable-amount shifts.
- Iterative unsigned shift-add multiply.
- Start/busy/done handshake toward the control FSM.
- Results and flags are registered and held until the next accepted start.
- Subtraction is true two's complement: carry-in = 1.
- SLT/SLTU place the result bit in the LSB.
- The zero flag covers every result bit.

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_seq_addsub.sv | 34 +++
 rtl/alu_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared definitions for the multi-cycle ALU. Holds the
//                operation codes, the controller state encoding and a small
//                op-decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Operation codes
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1011;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } state_t;

    // True for the three iterative shift operations
    function automatic logic is_shift(input logic [3:0] code);
        return (code == OP_SLL) || (code == OP_SRL) || (code == OP_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_addsub
//  Description : WIDTH-bit adder/subtractor. Subtraction is a + ~b + 1.
//                Shared by ADD, SUB, SLT, SLTU and the multiply accumulate.
//  Ports       : a, b       - operands
//                sub        - 1 selects subtraction
//                sum        - modulo 2^WIDTH result
//                carry_out  - carry out of the MSB (1 = no borrow on sub)
//                overflow   - signed overflow of the operation
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] w_b;

    assign w_b = sub ? ~b : b;

    assign {carry_out, sum} = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, sub};

    // Operands of equal sign producing a result of the other sign
    assign overflow = (a[WIDTH-1] == w_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Multi-cycle ALU with start/busy/done handshake. Logic and
//                add/sub/compare ops complete in one cycle; shifts iterate one
//                bit per cycle; MULU is an unsigned shift-add multiply.
//  Ports       : clk, reset (async, active high)
//                start, op, a, b, shamt  - request and operands
//                busy                    - multi-cycle op in progress
//                done                    - one-cycle completion pulse
//                result, result_hi       - result (hi half only for MULU)
//                zero, overflow          - flags, held with the result
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               zero,
    output logic               overflow
);

    // Counter must reach WIDTH for the multiply, one bit beyond a shift amount
    localparam int CNT_W = SHAMT_W + 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_work;      // shift operand, or multiplier / product low half
    logic [WIDTH-1:0]   r_acc;       // product high half
    logic [WIDTH-1:0]   r_mcand;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic               r_zero;
    logic               r_ovf;

    logic               w_accept;
    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_add_sub;
    logic [WIDTH-1:0]   w_add_sum;
    logic               w_add_carry;
    logic               w_add_ovf;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_shift_next;
    logic [WIDTH:0]     w_mul_sel;

    assign w_accept = start && (r_state == IDLE);

    // The adder serves the operands while idle and the accumulate while multiplying
    always_comb begin
        w_add_a   = a;
        w_add_b   = b;
        w_add_sub = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
        if (r_state == MUL) begin
            w_add_a   = r_acc;
            w_add_b   = r_mcand;
            w_add_sub = 1'b0;
        end
    end

    alu_seq_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a         (w_add_a),
        .b         (w_add_b),
        .sub       (w_add_sub),
        .sum       (w_add_sum),
        .carry_out (w_add_carry),
        .overflow  (w_add_ovf)
    );

    // Single-cycle result selection
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (op)
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NOR:  w_res = ~(a | b);
            OP_ADD,
            OP_SUB: begin
                w_res = w_add_sum;
                w_ovf = w_add_ovf;
            end
            // Sign of the true difference, corrected for overflow
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_add_sum[WIDTH-1] ^ w_add_ovf};
            // No carry out of a + ~b + 1 means a borrow, i.e. a < b
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, ~w_add_carry};
            default: w_res = '0;
        endcase
    end

    // One-bit shift step for the op captured at acceptance
    always_comb begin
        w_shift_next = r_work;
        case (r_op)
            OP_SLL:  w_shift_next = {r_work[WIDTH-2:0], 1'b0};
            OP_SRL:  w_shift_next = {1'b0, r_work[WIDTH-1:1]};
            OP_SRA:  w_shift_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            default: w_shift_next = r_work;
        endcase
    end

    // Multiply step: add the multiplicand into the high half when the current
    // multiplier bit is set; the carry becomes the new MSB after the shift.
    assign w_mul_sel = r_work[0] ? {w_add_carry, w_add_sum} : {1'b0, r_acc};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (is_shift(op)) begin
                        w_state_next = SHIFT;
                    end else if (op == OP_MULU) begin
                        w_state_next = MUL;
                    end
                end
            end
            SHIFT,
            MUL: begin
                if (r_cnt == '0) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op        <= '0;
            r_cnt       <= '0;
            r_work      <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op <= op;
                        if (is_shift(op)) begin
                            r_work <= b;
                            r_cnt  <= {1'b0, shamt};
                        end else if (op == OP_MULU) begin
                            r_mcand <= a;
                            r_work  <= b;
                            r_acc   <= '0;
                            r_cnt   <= CNT_W'(WIDTH);
                        end else begin
                            r_result    <= w_res;
                            r_result_hi <= '0;
                            r_zero      <= (w_res == '0);
                            r_ovf       <= w_ovf;
                            r_done      <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (r_cnt != '0) begin
                        r_work <= w_shift_next;
                        r_cnt  <= r_cnt - CNT_W'(1);
                    end else begin
                        r_result    <= r_work;
                        r_result_hi <= '0;
                        r_zero      <= (r_work == '0);
                        r_ovf       <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                MUL: begin
                    if (r_cnt != '0) begin
                        r_acc  <= w_mul_sel[WIDTH:1];
                        r_work <= {w_mul_sel[0], r_work[WIDTH-1:1]};
                        r_cnt  <= r_cnt - CNT_W'(1);
                    end else begin
                        r_result    <= r_work;
                        r_result_hi <= r_acc;
                        r_zero      <= (r_work == '0);
                        r_ovf       <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zero      = r_zero;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq. The driver pushes the
//                expected response and completion cycle for each request; a
//                monitor pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    op    = '0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic [SW-1:0] shamt = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          zero;
    logic          overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         v;
        int           due;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    exp_t m_e;
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                m_e = sb.pop_front();
                chk("result",     result,    m_e.res);
                chk("result_hi",  result_hi, m_e.hi);
                chk("zero",       zero,      m_e.z);
                chk("overflow",   overflow,  m_e.v);
                chk("done_cycle", cyc,       m_e.due);
            end
        end
    end

    // Drive one request; caller is positioned at a falling edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [SW-1:0] sh, input logic [W-1:0] er, input logic [W-1:0] eh,
                         input logic ez, input logic ev, input int lat);
        exp_t e;
        op    = o;
        a     = xa;
        b     = xb;
        shamt = sh;
        start = 1'b1;
        e.res = er;
        e.hi  = eh;
        e.z   = ez;
        e.v   = ev;
        e.due = cyc + 1 + lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        // Operands were captured; scramble them
        a     = $urandom();
        b     = $urandom();
        shamt = SW'($urandom_range(31));
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0 outstanding", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [SW-1:0] sh, input logic [W-1:0] er, input logic [W-1:0] eh,
                       input logic ez, input logic ev, input int lat);
        @(negedge clk);
        issue(o, xa, xb, sh, er, eh, ez, ev, lat);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_busy",   busy,      0);
        chk("rst_done",   done,      0);
        chk("rst_result", result,    0);
        chk("rst_hi",     result_hi, 0);
        chk("rst_zero",   zero,      1);
        chk("rst_ovf",    overflow,  0);
        reset = 1'b0;

        // ADD overflow, single cycle, busy stays low
        @(negedge clk);
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 0, 0, 1, 0);
        chk("add_busy", busy, 0);
        drain();

        // Back-to-back single-cycle ops, one per edge
        @(negedge clk); issue(OP_SUB,  32'd5,         32'd5,         0, 32'h0,         0, 1, 0, 0);
        @(negedge clk); issue(OP_SLT,  32'hFFFF_FFFF, 32'h1,         0, 32'h1,         0, 0, 0, 0);
        @(negedge clk); issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1,         0, 32'h0,         0, 1, 0, 0);
        @(negedge clk); issue(OP_SUB,  32'h8000_0000, 32'h1,         0, 32'h7FFF_FFFF, 0, 0, 1, 0);
        @(negedge clk); issue(OP_SLT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0,         0, 1, 0, 0);
        drain();
        run(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hF000_F000, 0, 0, 0, 0);
        run(OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hFFF0_FFF0, 0, 0, 0, 0);
        run(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'h0FF0_0FF0, 0, 0, 0, 0);
        run(OP_NOR, 32'h0,         32'h0,         0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        run(4'b1111, 32'hFFFF,     32'hFFFF,      0, 32'h0,         0, 1, 0, 0);

        // SRA with busy window N..N+4, done at N+5
        @(negedge clk);
        issue(OP_SRA, 0, 32'h8000_0000, 5'd4, 32'hF800_0000, 0, 0, 0, 5);
        chk("sra_busy", busy, 1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            chk("sra_busy", busy, 1);
        end
        @(posedge clk); #1;
        chk("sra_busy_end", busy, 0);
        drain();
        run(OP_SLL, 0, 32'h1234_5678, 5'd0,  32'h1234_5678, 0, 0, 0, 1);
        run(OP_SRL, 0, 32'hFFFF_FFFF, 5'd31, 32'h1,         0, 0, 0, 32);
        run(OP_SLL, 0, 32'h1,         5'd31, 32'h8000_0000, 0, 0, 0, 32);

        // MULU with an ignored start at N+10
        @(negedge clk);
        issue(OP_MULU, 32'hFFFF_FFFF, 32'h2, 0, 32'hFFFF_FFFE, 32'h1, 0, 0, 33);
        repeat (9) @(posedge clk);
        #1;
        op = OP_ADD; a = 32'h1; b = 32'h1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mul_busy_after_ignored", busy, 1);
        drain();
        run(OP_MULU, 32'h0001_0000, 32'h0001_0000, 0, 32'h0,       32'h1, 1, 0, 33);
        run(OP_MULU, 32'h1234,      32'h10,        0, 32'h12340,   32'h0, 0, 0, 33);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        issue(OP_MULU, 32'h1234, 32'h5678, 0, 32'h0, 0, 0, 0, 33);
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy",   busy,      0);
        chk("arst_done",   done,      0);
        chk("arst_result", result,    0);
        chk("arst_hi",     result_hi, 0);
        chk("arst_zero",   zero,      1);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        run(OP_ADD, 32'd3, 32'd4, 0, 32'd7, 0, 0, 0, 0);

        // SRL issued on the done cycle of an SLL
        @(negedge clk);
        issue(OP_SLL, 0, 32'h10, 5'd2, 32'h40, 0, 0, 0, 3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 50);
        issue(OP_SRL, 0, 32'h10, 5'd2, 32'h4, 0, 0, 0, 3);
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
